// File: rtl/reg_byte_serializer_pkg.sv
// Shared types and elaboration helpers
// for the register byte serializer.
package reg_byte_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Byte counter width: never below one bit.
  function automatic int cnt_width(
    input int total_bytes
  );
    return (total_bytes > 1) ?
      $clog2(total_bytes) : 1;
  endfunction

  // Legal shape: whole bytes per word,
  // at least one word per frame.
  function automatic bit params_ok(
    input int word_w,
    input int num_words
  );
    return (word_w >= 8) &&
           ((word_w % 8) == 0) &&
           (num_words >= 1);
  endfunction

endpackage

// File: rtl/reg_byte_serializer_if.sv
// Frame-in / byte-out handshake bundle
// of the register byte serializer.
interface reg_byte_serializer_if
  import reg_byte_serializer_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2
);

  localparam int FRAME_W = NUM_WORDS * WORD_W;
  localparam int TOTAL_BYTES = FRAME_W / 8;
  localparam int CNT_W = cnt_width(TOTAL_BYTES);

  logic [FRAME_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               msb_first;
  logic [7:0]         out_byte;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [CNT_W-1:0]   out_idx;
  logic               busy;
  logic [15:0]        frame_cnt;

  modport master (
    output in_data,
    output in_valid,
    output msb_first,
    output out_ready,
    input  in_ready,
    input  out_byte,
    input  out_valid,
    input  out_last,
    input  out_idx,
    input  busy,
    input  frame_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  msb_first,
    input  out_ready,
    output in_ready,
    output out_byte,
    output out_valid,
    output out_last,
    output out_idx,
    output busy,
    output frame_cnt
  );

endinterface

// File: rtl/reg_byte_serializer_select.sv
// Picks the byte for a given emission
// index out of a latched frame.
module reg_byte_select
  import reg_byte_serializer_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2
) (
  frame_i,
  idx_i,
  msb_first_i,
  byte_o
);

  localparam int FRAME_W = NUM_WORDS * WORD_W;
  localparam int TOTAL_BYTES = FRAME_W / 8;
  localparam int CNT_W = cnt_width(TOTAL_BYTES);

  input  logic [FRAME_W-1:0] frame_i;
  input  logic [CNT_W-1:0]   idx_i;
  input  logic               msb_first_i;
  output logic [7:0]         byte_o;

  int pos;

  // Map emission index to byte lane
  always_comb begin
    pos = msb_first_i ?
      (TOTAL_BYTES - 1 - int'(idx_i)) :
      int'(idx_i);
    byte_o = 8'h00;
    for (int i = 0; i < TOTAL_BYTES; i++) begin
      if (pos == i) begin
        byte_o = frame_i[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_byte_serializer.sv
// Accepts a register frame and emits it
// as a valid/ready byte stream.
module reg_byte_serializer
  import reg_byte_serializer_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2
) (
  input logic clk,
  input logic rst_n,
  reg_byte_serializer_if.slave bus
);

  localparam int FRAME_W = NUM_WORDS * WORD_W;
  localparam int TOTAL_BYTES = FRAME_W / 8;
  localparam int CNT_W = cnt_width(TOTAL_BYTES);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TOTAL_BYTES - 1);

  if (!params_ok(WORD_W, NUM_WORDS)) begin : g_bad
    $fatal(1, "illegal WORD_W/NUM_WORDS");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               msb_q, msb_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic [7:0] sel_byte;
  logic       send;
  logic       is_last;
  logic       xfer;
  logic       ready;
  logic       accept;

  reg_byte_select #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_sel (
    .frame_i     (frame_q),
    .idx_i       (cnt_q),
    .msb_first_i (msb_q),
    .byte_o      (sel_byte)
  );

  // Handshake qualifiers; ready reopens on the
  // final transfer so frames chain bubble-free
  always_comb begin
    send    = (state_q == SEND);
    is_last = send && (cnt_q == LAST);
    xfer    = send && bus.out_ready;
    ready   = !send || (xfer && is_last);
    accept  = bus.in_valid && ready;
  end

  // Next state, counter, frame latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    msb_d   = msb_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          cnt_d   = '0;
          frame_d = bus.in_data;
          msb_d   = bus.msb_first;
        end
      end
      SEND: begin
        if (xfer) begin
          if (is_last) begin
            fcnt_d = fcnt_q + 16'd1;
            cnt_d  = '0;
            if (accept) begin
              frame_d = bus.in_data;
              msb_d   = bus.msb_first;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      msb_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      msb_q   <= msb_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = send;
  assign bus.out_byte  = send ? sel_byte : 8'h00;
  assign bus.out_last  = is_last;
  assign bus.out_idx   = cnt_q;
  assign bus.busy      = send;
  assign bus.frame_cnt = fcnt_q;

endmodule

// File: tb/tb_reg_byte_serializer.sv
// Randomised self-checking bench for the
// register byte serializer.
module tb_reg_byte_serializer;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  reg_byte_serializer_if #(
    .WORD_W(32), .NUM_WORDS(2)) ia ();
  reg_byte_serializer_if #(
    .WORD_W(16), .NUM_WORDS(1)) ib ();
  reg_byte_serializer_if #(
    .WORD_W(8), .NUM_WORDS(1)) ic ();

  reg_byte_serializer #(
    .WORD_W(32), .NUM_WORDS(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  reg_byte_serializer #(
    .WORD_W(16), .NUM_WORDS(1)
  ) dut_b (
    .clk(clk), .rst_n(rst2_n), .bus(ib.slave)
  );

  reg_byte_serializer #(
    .WORD_W(8), .NUM_WORDS(1)
  ) dut_c (
    .clk(clk), .rst_n(rst2_n), .bus(ic.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_fcnt = 0;

  localparam logic [63:0] F1 =
    {32'hA1B2C3D4, 32'h11223344};
  localparam logic [63:0] F2 =
    {32'hDEADBEEF, 32'h00000000};

  // Byte k of a frame in emission order.
  function automatic logic [7:0] ref_byte(
    input logic [63:0] f, input int total,
    input bit msb, input int k);
    int pos;
    logic [63:0] s;
    pos = msb ? (total - 1 - k) : k;
    s = f >> (pos * 8);
    return s[7:0];
  endfunction

  task automatic accept_a(
    input logic [63:0] f, input bit msb);
    @(negedge clk);
    ia.in_valid  = 1'b1;
    ia.in_data   = f;
    ia.msb_first = msb;
    ia.out_ready = 1'($urandom);
    #1;
    n_cmp++;
    if ({ia.in_ready, ia.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL accept_idle: rdy/vld=%b need 10",
        {ia.in_ready, ia.out_valid});
    end
    @(negedge clk);
  endtask

  task automatic stream_a(
    input logic [63:0] f, input bit msb,
    input int stall_k, input int stall_n,
    input bit chain, input logic [63:0] nf,
    input bit nmsb, output int cycles);
    int k;
    int stall;
    bit done;
    bit rdy;
    bit lst;
    logic [14:0] got;
    logic [14:0] exp;
    k = 0;
    stall = stall_n;
    cycles = 0;
    done = 1'b0;
    for (int it = 0; it < 64 && !done; it++) begin
      lst = (k == 7);
      rdy = !(k == stall_k && stall > 0);
      ia.out_ready = rdy;
      if (lst && rdy) begin
        ia.in_valid = chain;
        ia.in_data = chain ? nf :
          {$urandom, $urandom};
        ia.msb_first = chain ? nmsb :
          1'($urandom);
      end else begin
        ia.in_valid = 1'($urandom);
        ia.in_data = {$urandom, $urandom};
        ia.msb_first = 1'($urandom);
      end
      #1;
      got = {ia.out_valid, ia.out_byte,
             ia.out_idx, ia.out_last,
             ia.busy, ia.in_ready};
      exp = {1'b1, ref_byte(f, 8, msb, k),
             3'(k), lst, 1'b1, lst && rdy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL byte k=%0d: got %h need %h",
          k, got, exp);
      end
      cycles++;
      if (!rdy) stall--;
      else if (lst) begin
        done = 1'b1;
        exp_fcnt++;
      end else k++;
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL stream_timeout: k=%0d need 7", k);
    end
    if (!chain) begin
      ia.in_valid = 1'b0;
      #1;
      n_cmp++;
      if ({ia.out_valid, ia.busy, ia.in_ready,
           ia.frame_cnt} !==
          {3'b001, 16'(exp_fcnt)}) begin
        n_err++;
        $display("FAIL frame_end: got %b/%0d need 001/%0d",
          {ia.out_valid, ia.busy, ia.in_ready},
          ia.frame_cnt, exp_fcnt);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    rst2_n = 1'b1;
    #1;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    ia.in_valid = 1'b1;
    #2;
    n_cmp++;
    if ({ia.out_valid, ia.out_byte, ia.out_idx,
         ia.out_last, ia.busy, ia.frame_cnt,
         ib.out_valid, ic.out_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_state: byte=%h idx=%0d vld=%b need 0",
        ia.out_byte, ia.out_idx, ia.out_valid);
    end
    ia.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ia.in_ready, ib.in_ready, ic.in_ready,
         ia.out_valid} !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_release: got %b need 1110",
        {ia.in_ready, ib.in_ready, ic.in_ready,
         ia.out_valid});
    end
  endtask

  task automatic test_order(input bit msb);
    int cyc;
    accept_a(F1, msb);
    stream_a(F1, msb, -1, 0, 1'b0, '0, 1'b0, cyc);
    n_cmp++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL order_len msb=%0d: got %0d need 8",
        msb, cyc);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    accept_a(F1, 1'b1);
    stream_a(F1, 1'b1, 2, 3, 1'b0, '0, 1'b0, cyc);
    n_cmp++;
    if (cyc !== 11) begin
      n_err++;
      $display("FAIL stall_len: got %0d need 11", cyc);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    accept_a(F1, 1'b1);
    stream_a(F1, 1'b1, -1, 0, 1'b1, F2, 1'b1, cyc);
    stream_a(F2, 1'b1, -1, 0, 1'b0, '0, 1'b0, cyc);
  endtask

  task automatic test_reset_mid;
    int cyc;
    accept_a(F1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ia.in_valid = 1'b0;
      ia.out_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (ia.out_byte !== 8'hD4) begin
      n_err++;
      $display("FAIL mid_byte3: got %h need d4",
        ia.out_byte);
    end
    #1;
    rst_n = 1'b0;
    #1;
    exp_fcnt = 0;
    n_cmp++;
    if ({ia.out_valid, ia.out_byte, ia.out_idx,
         ia.out_last, ia.busy,
         ia.frame_cnt} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: byte=%h cnt=%0d need 0",
        ia.out_byte, ia.frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ia.in_ready, ia.out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_release: got %b need 10",
        {ia.in_ready, ia.out_valid});
    end
    accept_a(F2, 1'b0);
    stream_a(F2, 1'b0, -1, 0, 1'b0, '0, 1'b0, cyc);
  endtask

  task automatic test_random;
    logic [63:0] cur;
    logic [63:0] nf;
    bit cm;
    bit nm;
    bit ch;
    int sk;
    int sn;
    int cyc;
    cur = {$urandom, $urandom};
    cm = 1'($urandom);
    accept_a(cur, cm);
    for (int i = 0; i < 20; i++) begin
      nf = {$urandom, $urandom};
      nm = 1'($urandom);
      ch = (i < 19) && ($urandom_range(0, 1) == 1);
      sk = $urandom_range(0, 7);
      sn = $urandom_range(0, 3);
      stream_a(cur, cm, sk, sn, ch, nf, nm, cyc);
      n_cmp++;
      if (cyc !== 8 + sn) begin
        n_err++;
        $display("FAIL rand_len %0d: got %0d need %0d",
          i, cyc, 8 + sn);
      end
      if (i < 19) begin
        if (!ch) accept_a(nf, nm);
        cur = nf;
        cm = nm;
      end
    end
  endtask

  task automatic test_param16;
    int fb;
    logic [11:0] got;
    logic [11:0] exp;
    fb = 0;
    for (int m = 1; m >= 0; m--) begin
      @(negedge clk);
      ib.in_valid = 1'b1;
      ib.in_data = 16'hBEEF;
      ib.msb_first = 1'(m);
      ib.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ib.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL w16_ready: got %b need 1",
          ib.in_ready);
      end
      @(negedge clk);
      ib.in_valid = 1'b0;
      ib.in_data = 16'($urandom);
      ib.msb_first = ~ib.msb_first;
      for (int k = 0; k < 2; k++) begin
        #1;
        got = {ib.out_valid, ib.out_byte,
               ib.out_idx, ib.out_last, ib.busy};
        exp = {1'b1,
               ref_byte(64'hBEEF, 2, m == 1, k),
               1'(k), k == 1, 1'b1};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL w16 m=%0d k=%0d: got %h need %h",
            m, k, got, exp);
        end
        @(negedge clk);
      end
      fb++;
      #1;
      n_cmp++;
      if ({ib.out_valid, ib.frame_cnt} !==
          {1'b0, 16'(fb)}) begin
        n_err++;
        $display("FAIL w16_end: vld=%b cnt=%0d need 0/%0d",
          ib.out_valid, ib.frame_cnt, fb);
      end
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] d [2];
    d[0] = 8'($urandom);
    d[1] = 8'($urandom);
    @(negedge clk);
    ic.in_valid = 1'b1;
    ic.in_data = d[0];
    ic.msb_first = 1'($urandom);
    ic.out_ready = 1'b1;
    @(negedge clk);
    ic.in_data = d[1];
    ic.msb_first = 1'($urandom);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if ({ic.out_valid, ic.out_byte, ic.out_last,
           ic.in_ready} !==
          {1'b1, d[k], 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL w8 k=%0d: byte=%h last=%b need %h/1",
          k, ic.out_byte, ic.out_last, d[k]);
      end
      @(negedge clk);
      ic.in_valid = 1'b0;
    end
    #1;
    n_cmp++;
    if ({ic.out_valid, ic.frame_cnt} !==
        {1'b0, 16'd2}) begin
      n_err++;
      $display("FAIL w8_end: vld=%b cnt=%0d need 0/2",
        ic.out_valid, ic.frame_cnt);
    end
  endtask

  initial begin
    ia.in_valid = 1'b0;
    ia.in_data = '0;
    ia.msb_first = 1'b0;
    ia.out_ready = 1'b0;
    ib.in_valid = 1'b0;
    ib.in_data = '0;
    ib.msb_first = 1'b0;
    ib.out_ready = 1'b0;
    ic.in_valid = 1'b0;
    ic.in_data = '0;
    ic.msb_first = 1'b0;
    ic.out_ready = 1'b0;
    test_reset();
    test_order(1'b1);
    test_order(1'b0);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_param16();
    test_single_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_byte_serializer.md
REG_BYTE_SERIALIZER -- requirements
Module: reg_byte_serializer

Interface
REQ-001 SHALL provide parameter WORD_W, default 32, register word width in bits; must be a multiple of 8.
REQ-002 SHALL provide parameter NUM_WORDS, default 2, number of register words per frame; must be at least 1.
REQ-003 SHALL derive localparams TOTAL_BYTES = NUM_WORDS*WORD_W/8 and CNT_W = max(1, clog2(TOTAL_BYTES)).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port in_data, input, NUM_WORDS*WORD_W bits: frame; word 0 occupies the most-significant WORD_W bits.
REQ-008 Port in_valid, input, 1 bit: frame offer.
REQ-009 Port in_ready, output, 1 bit: frame acceptance.
REQ-010 Port msb_first, input, 1 bit: byte order, sampled only at frame accept.
REQ-011 Port out_byte, output, 8 bits: current byte.
REQ-012 Port out_valid, output, 1 bit: out_byte is valid.
REQ-013 Port out_ready, input, 1 bit: consumer accepts the current byte.
REQ-014 Port out_last, output, 1 bit: final byte of the frame.
REQ-015 Port out_idx, output, CNT_W bits: emission index of the current byte, starting at 0.
REQ-016 Port busy, output, 1 bit: high while a frame is held.
REQ-017 Port frame_cnt, output, 16 bits: count of completed frames; wraps.

Function
REQ-018 SHALL implement two states, IDLE and SEND.
REQ-019 Frame accept occurs when in_valid && in_ready.
- On accept: latch in_data and msb_first.
- Clear the byte counter.
- Enter SEND.
REQ-020 in_ready SHALL equal (state==IDLE) || (out_valid && out_ready && out_last), so back-to-back frames run with zero bubble.
REQ-021 Latency: the first byte SHALL appear on out_valid in the cycle after accept.
REQ-022 Byte order:
- msb_first=1 emits byte k = latched[(TOTAL_BYTES-k)*8-1 -: 8].
- msb_first=0 emits byte k = latched[k*8+7 -: 8].
REQ-023 out_valid SHALL be 1 exactly in SEND.
REQ-024 While out_valid && !out_ready, out_byte, out_idx and out_last SHALL hold stable.
REQ-025 On out_valid && out_ready, the counter SHALL advance by 1.
REQ-026 out_last SHALL equal (counter == TOTAL_BYTES-1).
REQ-027 On the transfer of the last byte:
- Increment frame_cnt modulo 2^16.
- With a simultaneous accept, reload and stay in SEND.
- Otherwise return to IDLE.
REQ-028 busy SHALL equal (state==SEND).
REQ-029 With TOTAL_BYTES==1, every byte SHALL assert out_last.
REQ-030 in_data and msb_first changes while in SEND SHALL have no effect on the frame in flight.

Reset
REQ-031 While rst_n==0, the block SHALL asynchronously force:
- state=IDLE, counter=0, latched frame=0.
- out_valid=0, out_byte=0x00, out_last=0, out_idx=0.
- busy=0, frame_cnt=0.
REQ-032 in_ready SHALL be 1 from the first clock after rst_n deasserts.
REQ-033 Reset mid-frame SHALL discard the frame; no partial frame is counted or resumed.

Structure
REQ-034 A shared package SHALL hold:
- the state enum (IDLE, SEND);
- the clog2-based counter-width helper;
- the parameter-legality check.
REQ-035 An illegal WORD_W or NUM_WORDS SHALL stop elaboration.
REQ-036 Byte selection SHALL sit in one combinational sub-module, reg_byte_select (frame, index, msb_first -> byte).
REQ-037 Handshake/FSM and counters SHALL live in the top.

Verification
REQ-038 MSB-first: defaults, in_data={32'hA1B2C3D4,32'h11223344}, msb_first=1, out_ready=1 -> bytes A1,B2,C3,D4,11,22,33,44 on 8 consecutive cycles; out_last only on 44; frame_cnt=1.
REQ-039 LSB-first: same frame, msb_first=0 -> 44,33,22,11,D4,C3,B2,A1.
REQ-040 Backpressure: out_ready low for 3 cycles at idx 2 -> out_byte=C3 and idx=2 held; total frame takes 11 cycles.
REQ-041 Back-to-back: second frame {32'hDEADBEEF,32'h0} offered at the last transfer -> DE follows 44 the next cycle, no gap; frame_cnt=2.
REQ-042 Reset mid-frame: rst_n low after byte 3 -> all outputs 0 immediately, frame_cnt=0, in_ready=1 after release.
REQ-043 Parameterised: WORD_W=16, NUM_WORDS=1, frame 16'hBEEF, msb_first=1 -> BE,EF; out_last on EF.
